counter_ctrl_unit: RTL and testbench

//   Control unit for the dedicated 0..10 counter datapath. Moore FSM sequencing A-reg clear,

---
 rtl/counter_ctrl_unit.sv | 116 +++++++++++
 tb/tb_counter_ctrl_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl_unit.sv
// Moore control FSM for the 0..10 counter datapath: clears A, compares A<10, shows each
// value for TICK_DIV cycles (pausable), increments, and signals completion with a done pulse.
module counter_ctrl_unit #(
   parameter int TICK_DIV = 4,
   parameter int TICK_W   = $clog2(TICK_DIV + 1)
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iStart,
   input  logic       iPause,
   input  logic       iAlt10,
   output logic       oAsrcSel,
   output logic       oALoad,
   output logic       oOufBufSel,
   output logic       oBusy,
   output logic       oDone,
   output logic [2:0] oState
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_CMP  = 3'd2,
      S_SHOW = 3'd3,
      S_INC  = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   state_t            state_q, state_d;
   logic [TICK_W-1:0] presc_q, presc_d;
   logic              show_q, show_d;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         show_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         show_q  <= show_d;
      end
   end

   // Prescaler is forced to 0 outside SHOW so every value starts a fresh hold period.
   always_comb begin
      state_d = S_IDLE;
      presc_d = '0;
      show_d  = show_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
            if (iStart) begin
               state_d = S_INIT;
               show_d  = 1'b0;
            end
         end
         S_INIT: state_d = S_CMP;
         S_CMP:  state_d = iAlt10 ? S_SHOW : S_HALT;
         S_SHOW: begin
            show_d  = 1'b1;
            state_d = S_SHOW;
            presc_d = presc_q;
            if (!iPause) begin
               if (presc_q == TICK_LAST) begin
                  state_d = S_INC;
                  presc_d = '0;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
         end
         S_INC:  state_d = S_CMP;
         S_HALT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Show-latch keeps the final value on the bus while parked in IDLE.
   always_comb begin
      oAsrcSel   = 1'b0;
      oALoad     = 1'b0;
      oOufBufSel = show_q;
      oBusy      = 1'b0;
      oDone      = 1'b0;
      case (state_q)
         S_INIT: begin
            oALoad     = 1'b1;
            oOufBufSel = 1'b0;
            oBusy      = 1'b1;
         end
         S_CMP:  oBusy = 1'b1;
         S_SHOW: begin
            oOufBufSel = 1'b1;
            oBusy      = 1'b1;
         end
         S_INC: begin
            oAsrcSel   = 1'b1;
            oALoad     = 1'b1;
            oOufBufSel = 1'b1;
            oBusy      = 1'b1;
         end
         S_HALT: begin
            oOufBufSel = 1'b1;
            oBusy      = 1'b1;
            oDone      = 1'b1;
         end
         default: ;
      endcase
   end

   assign oState = state_q;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Bench for counter_ctrl_unit: directed timing/pause/reset runs plus randomized runs checked
// against a trace built from the run sequence rules, with a simple A-register datapath model.
module tb_counter_ctrl_unit;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       iRst = 1'b1, iStart = 1'b0, iPause = 1'b0, iAlt10;
   logic       oAsrcSel, oALoad, oOufBufSel, oBusy, oDone;
   logic [2:0] oState;
   logic [4:0] a_reg = 5'd0;

   int vectors = 0;
   int miscompares = 0;

   counter_ctrl_unit #(.TICK_DIV(N)) dut (
      .iClk(clk), .iRst(iRst), .iStart(iStart), .iPause(iPause), .iAlt10(iAlt10),
      .oAsrcSel(oAsrcSel), .oALoad(oALoad), .oOufBufSel(oOufBufSel), .oBusy(oBusy),
      .oDone(oDone), .oState(oState)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: A-reg loads 0 or A+1, flag is A<10.
   always @(posedge clk) if (oALoad) a_reg <= oAsrcSel ? a_reg + 5'd1 : 5'd0;
   assign iAlt10 = (a_reg < 5'd10);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected {AsrcSel,ALoad,OufBufSel,Busy,Done} for a state code and latch value.
   function automatic logic [4:0] exp_outs(input logic [2:0] st, input logic shown_v);
      case (st)
         3'd1:    return 5'b01010;
         3'd2:    return {2'b00, shown_v, 2'b10};
         3'd3:    return 5'b00110;
         3'd4:    return 5'b11110;
         3'd5:    return 5'b00111;
         default: return {2'b00, shown_v, 2'b00};
      endcase
   endfunction

   // Reference trace: per-cycle stimulus and expected state / latch value.
   logic       q_start[$], q_pause[$], q_shown[$];
   logic [2:0] q_st[$];
   logic       shown;

   function automatic void emit(input logic [2:0] st, input logic s, input logic p);
      q_start.push_back(s);
      q_pause.push_back(p);
      q_st.push_back(st);
      q_shown.push_back(shown);
      if (st == 3'd3) shown = 1'b1;
   endfunction

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   // One run: gap idle cycles, accept, INIT, 11 compares with N unpaused SHOW cycles per value.
   function automatic void gen_run(input int gap, input int pct);
      int held;
      logic p;
      for (int g = 0; g < gap; g++) emit(3'd0, 1'b0, rb());
      emit(3'd0, 1'b1, rb());
      shown = 1'b0;
      emit(3'd1, rb(), rb());
      for (int k = 0; k <= 10; k++) begin
         emit(3'd2, rb(), rb());
         if (k == 10) break;
         held = 0;
         while (held < N) begin
            p = ($urandom_range(0, 99) < pct);
            emit(3'd3, rb(), p);
            if (!p) held++;
         end
         emit(3'd4, rb(), rb());
      end
      emit(3'd5, rb(), rb());
   endfunction

   task automatic replay();
      logic [2:0] st;
      logic       sh;
      while (q_st.size() > 0) begin
         st = q_st.pop_front();
         sh = q_shown.pop_front();
         iStart = q_start.pop_front();
         iPause = q_pause.pop_front();
         chk("rand_state", 32'(oState), 32'(st));
         chk("rand_outs", 32'({oAsrcSel, oALoad, oOufBufSel, oBusy, oDone}), 32'(exp_outs(st, sh)));
         if (st == 3'd5) chk("rand_a_final", 32'(a_reg), 32'd10);
         @(posedge clk); #1;
      end
      iStart = 1'b0;
      iPause = 1'b0;
   endtask

   // Start at cycle 0; optionally pause pn cycles while showing value pa.
   task automatic timed_run(input int pa, input int pn, output int done_c, output int loads);
      int paused;
      paused = 0;
      done_c = -1;
      loads  = 0;
      for (int c = 0; c < 300 && done_c < 0; c++) begin
         iStart = (c == 0);
         iPause = 1'b0;
         if (oState == 3'd3 && int'(a_reg) == pa && paused < pn) begin
            iPause = 1'b1;
            paused++;
         end
         if (oALoad) loads++;
         if (oDone) done_c = c;
         @(posedge clk); #1;
      end
      iStart = 1'b0;
      iPause = 1'b0;
   endtask

   initial begin
      int done_c, loads;
      logic found;

      // Reset with arbitrary inputs
      for (int i = 0; i < 2; i++) begin
         iStart = rb();
         iPause = rb();
         @(posedge clk);
      end
      #1;
      chk("reset_state", 32'(oState), 32'd0);
      chk("reset_outs", 32'({oAsrcSel, oALoad, oOufBufSel, oBusy, oDone}), 32'd0);
      iRst = 1'b0;
      iStart = 1'b0;
      iPause = 1'b0;
      @(posedge clk); #1;

      // Full run, no pause: done at cycle 10N+23
      timed_run(-1, 0, done_c, loads);
      chk("run_done_cycle", 32'(done_c), 32'd63);
      chk("run_loads", 32'(loads), 32'd11);
      chk("run_a_final", 32'(a_reg), 32'd10);
      chk("run_idle_state", 32'(oState), 32'd0);
      chk("run_idle_outs", 32'({oAsrcSel, oALoad, oOufBufSel, oBusy, oDone}), 32'b00100);

      // Pause 7 cycles while showing 3
      timed_run(3, 7, done_c, loads);
      chk("pause_done_cycle", 32'(done_c), 32'd70);
      chk("pause_loads", 32'(loads), 32'd11);
      chk("pause_a_final", 32'(a_reg), 32'd10);

      // Mid-run reset while showing 5
      iStart = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (oState == 3'd3 && a_reg == 5'd5) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("mid_reach_a5", 32'(found), 32'd1);
      iRst = 1'b1;
      @(posedge clk); #1;
      iRst = 1'b0;
      chk("mid_reset_state", 32'(oState), 32'd0);
      chk("mid_reset_outs", 32'({oAsrcSel, oALoad, oOufBufSel, oBusy, oDone}), 32'd0);
      chk("mid_reset_a_kept", 32'(a_reg), 32'd5);
      iStart = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
      chk("restart_init", 32'(oState), 32'd1);
      @(posedge clk); #1;
      chk("restart_a_clear", 32'(a_reg), 32'd0);
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (oDone) found = 1'b1;
         @(posedge clk); #1;
      end
      chk("restart_done", 32'(found), 32'd1);

      // Randomized runs: random gaps (incl. back-to-back), pauses and ignored start pulses
      shown = 1'b1;
      for (int r = 0; r < 8; r++) begin
         gen_run((r == 1) ? 0 : int'($urandom_range(0, 3)), (r == 0) ? 0 : int'($urandom_range(0, 40)));
         replay();
      end
      chk("end_idle", 32'(oState), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
